// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI slave bridge.
package spi_pkg;
  localparam int BYTE_W        = 8;
  localparam int BIT_CNT_W     = 3;
  localparam int MIN_CLK_RATIO = 8;

  typedef enum logic {SPI_IDLE, SPI_ACTIVE} spi_state_e;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with a synchronised level
// and single-clk rise/fall strobes derived from consecutive samples.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= {SYNC_STAGES{RST_VAL}};
      prev_reg <= RST_VAL;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;
endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave, MSB first, fully oversampled in the clk domain.
// Optional macro SPI_FRAME_ERR_EN adds a sticky frame_err for mid-byte aborts.
module spi_bridge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              byte_sync,
  output logic [BYTE_W-1:0] rx_data,
  input  logic [BYTE_W-1:0] tx_data
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic mosi_s;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs_n),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_mosi_sync
      always_ff @(posedge clk) begin
        if (rst) mosi_sync_reg[gi] <= 1'b0;
        else if (gi == 0) mosi_sync_reg[gi] <= mosi;
        else mosi_sync_reg[gi] <= mosi_sync_reg[(gi == 0) ? 0 : gi-1];
      end
    end
  endgenerate
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  spi_state_e state_reg, state_next;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [BYTE_W-1:0]    rx_shift_reg, tx_shift_reg, rx_data_reg;
  logic                 miso_reg, byte_sync_reg, armed_reg;
  logic [2:0]           flush_cnt_reg;
  logic [BYTE_W-1:0]    rx_next;

  assign rx_next = {rx_shift_reg[BYTE_W-2:0], mosi_s};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= SPI_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SPI_IDLE:   if (cs_fall && armed_reg) state_next = SPI_ACTIVE;
      SPI_ACTIVE: if (cs_rise) state_next = SPI_IDLE;
      default:    state_next = SPI_IDLE;
    endcase
  end

`ifdef SPI_FRAME_ERR_EN
  logic                 frame_err_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_after;
  assign bit_cnt_after = sclk_rise ? bit_cnt_reg + 1'b1 : bit_cnt_reg;
  assign frame_err     = frame_err_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg   <= '0;
      rx_shift_reg  <= '0;
      tx_shift_reg  <= '0;
      rx_data_reg   <= '0;
      miso_reg      <= 1'b0;
      byte_sync_reg <= 1'b0;
      armed_reg     <= 1'b0;
      flush_cnt_reg <= '0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_reg <= 1'b0;
`endif
    end else begin
      byte_sync_reg <= 1'b0;
      // Only trust cs_n once the synchroniser holds real pin samples, so a
      // reset taken mid-frame cannot arm off the reset value of the chain.
      if (flush_cnt_reg < 3'(SYNC_STAGES)) flush_cnt_reg <= flush_cnt_reg + 1'b1;
      else if (cs_s) armed_reg <= 1'b1;

      case (state_reg)
        SPI_IDLE: begin
          bit_cnt_reg <= '0;
          miso_reg    <= 1'b0;
          if (cs_fall && armed_reg) begin
            tx_shift_reg <= tx_data;
            miso_reg     <= tx_data[BYTE_W-1];
`ifdef SPI_FRAME_ERR_EN
            frame_err_reg <= 1'b0;
`endif
          end
        end
        SPI_ACTIVE: begin
          if (sclk_rise) begin
            rx_shift_reg <= rx_next;
            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == '1) begin
              rx_data_reg   <= rx_next;
              byte_sync_reg <= 1'b1;
            end
          end
          if (sclk_fall) begin
            if (bit_cnt_reg == '0) begin
              tx_shift_reg <= tx_data;
              miso_reg     <= tx_data[BYTE_W-1];
            end else begin
              tx_shift_reg <= tx_shift_reg << 1;
              miso_reg     <= tx_shift_reg[BYTE_W-2];
            end
          end
          // An edge coincident with cs_rise is still handled above.
          if (cs_rise) begin
            bit_cnt_reg <= '0;
            miso_reg    <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            if (bit_cnt_after != '0) frame_err_reg <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign miso      = miso_reg;
  assign byte_sync = byte_sync_reg;
  assign rx_data   = rx_data_reg;
endmodule

// File: tb/tb_spi_bridge.sv
// Randomised scoreboard bench for spi_bridge: a bit-level SPI master drives
// frames, expected bytes are queued and a monitor checks each byte_sync.
module tb_spi_bridge;
  localparam int HALF = 5;  // sclk half period in clk cycles (10x ratio)

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi, miso, byte_sync;
  logic [7:0] rx_data, tx_data;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  spi_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .byte_sync(byte_sync), .rx_data(rx_data), .tx_data(tx_data)
`ifdef SPI_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb_q[$];
  logic [7:0] exp_b;
  logic [7:0] last_rx;
  logic [7:0] f_mosi[4];
  logic [7:0] f_tx[4];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One master bit slot: drive MOSI, sample MISO at the rising edge.
  task automatic do_bit(input int idx, input bit live, input bit cs_at_rise);
    logic [7:0] mb;
    logic       exp_m;
    mb    = f_mosi[idx/8];
    exp_m = live ? f_tx[idx/8][7 - idx%8] : 1'b0;
    mosi  = mb[7 - idx%8];
    clk_wait(HALF);
    chk($sformatf("miso_bit%0d", idx), {7'd0, miso}, {7'd0, exp_m});
    sclk = 1'b1;
    if (cs_at_rise) cs_n = 1'b1;
    if (live && idx%8 == 7) begin
      sb_q.push_back(mb);
      last_rx = mb;
    end
    for (int k = 0; k < HALF; k++) begin
      clk_wait(1);
      if (live && idx%8 == 7 && byte_sync) tx_data = f_tx[idx/8 + 1];
    end
    sclk = 1'b0;
  endtask

  task automatic run_frame(input int nbits, input bit cs_with_last);
    tx_data = f_tx[0];
    clk_wait(2);
    cs_n = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    clk_wait(4);
    chk("frame_err_clear", {7'd0, frame_err}, 8'd0);
`endif
    for (int i = 0; i < nbits; i++) do_bit(i, 1'b1, cs_with_last && i == nbits-1);
    if (!cs_with_last) begin
      clk_wait(HALF);
      cs_n = 1'b1;
    end
    clk_wait(8);
    chk("rx_data_hold", rx_data, last_rx);
    chk("miso_idle", {7'd0, miso}, 8'd0);
`ifdef SPI_FRAME_ERR_EN
    chk("frame_err_end", {7'd0, frame_err}, {7'd0, (nbits % 8) != 0});
`endif
  endtask

  always @(negedge clk) begin
    if (byte_sync) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL byte_sync_unexpected: got rx_data %h, want no pulse", rx_data);
      end else begin
        exp_b = sb_q.pop_front();
        if (rx_data !== exp_b) begin
          n_err++;
          $display("FAIL rx_byte: got %h, want %h", rx_data, exp_b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_data = 8'h00;
    last_rx = 8'h00;
    clk_wait(3);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_byte_sync", {7'd0, byte_sync}, 8'd0);
    chk("rst_miso", {7'd0, miso}, 8'd0);
    rst = 1'b0;
    clk_wait(10);

    // sclk toggling with cs_n high must be ignored
    f_mosi[0] = 8'hFF; f_tx[0] = 8'hFF; tx_data = 8'hFF;
    for (int i = 0; i < 8; i++) do_bit(i, 1'b0, 1'b0);
    clk_wait(8);
    chk("idle_rx_data", rx_data, 8'h00);

    // single byte A5 in, 3C out
    f_mosi[0] = 8'hA5; f_tx[0] = 8'h3C; f_tx[1] = 8'h00;
    run_frame(8, 1'b0);

    // two-byte frame, second MISO byte supplied after first byte_sync
    f_mosi[0] = 8'h85; f_mosi[1] = 8'h7E;
    f_tx[0] = 8'h11; f_tx[1] = 8'hC3; f_tx[2] = 8'h00;
    run_frame(16, 1'b0);

    // abort after 5 bits
    f_mosi[0] = 8'hFF; f_tx[0] = 8'h96;
    run_frame(5, 1'b0);

    // reset mid-frame with cs_n held low: no byte until re-armed
    f_mosi[0] = 8'hF0; f_tx[0] = 8'hA0;
    tx_data = f_tx[0];
    clk_wait(2);
    cs_n = 1'b0;
    for (int i = 0; i < 3; i++) do_bit(i, 1'b1, 1'b0);
    rst = 1'b1;
    clk_wait(2);
    sb_q.delete();
    last_rx = 8'h00;
    rst = 1'b0;
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_byte_sync", {7'd0, byte_sync}, 8'd0);
    f_mosi[0] = 8'hC7;
    for (int i = 0; i < 8; i++) do_bit(i, 1'b0, 1'b0);
    clk_wait(HALF);
    cs_n = 1'b1;
    clk_wait(10);
    chk("midrst_no_byte", rx_data, 8'h00);
    f_mosi[0] = 8'h5A; f_tx[0] = 8'h69;
    run_frame(8, 1'b0);

    // 8th rising sclk coincident with cs_n rising
    f_mosi[0] = 8'(($urandom_range(0, 255))); f_tx[0] = 8'(($urandom_range(0, 255)));
    run_frame(8, 1'b1);

    // randomised frames
    for (int f = 0; f < 20; f++) begin
      nb = $urandom_range(1, 24);
      for (int j = 0; j < 4; j++) begin
        f_mosi[j] = 8'($urandom_range(0, 255));
        f_tx[j]   = 8'($urandom_range(0, 255));
      end
      run_frame(nb, (nb % 8 == 0) && ($urandom_range(0, 1) == 1));
    end

    clk_wait(10);
    chk("scoreboard_empty", 8'(sb_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_bridge.md
Name: spi_bridge

Overview:
SPI slave front end of the PWM generator's register-access path. Sits directly upstream of the instruction decoder.
- Deserialises MOSI bytes into byte_sync/rx_data.
- Serialises tx_data (register read data from the decoder) onto MISO.
- Runs entirely in the clk domain: sclk and cs_n are oversampled, not used as clocks. SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
SYNC_STAGES, 2, flops in each input synchroniser (sclk, cs_n, mosi); legal range 2..4.

Ports:
clk  input  1  peripheral clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
sclk  input  1  SPI serial clock from master, asynchronous to clk
cs_n  input  1  SPI chip select, active low, asynchronous
mosi  input  1  master-out serial data
miso  output  1  slave-out serial data, registered
byte_sync  output  1  one-clk pulse: rx_data holds a new complete byte
rx_data  output  8  last received byte; stable until next byte_sync
tx_data  input  8  byte to shift out on MISO during the next byte slot

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: miso=0, byte_sync=0, rx_data=8'h00, bit_cnt=0, rx_shift=0, tx_shift=0, armed=0. sclk synchroniser stages reset to 0; cs_n stages reset to 1; mosi stages reset to 0.
- Edge detection: on synchronised signals, previous vs current sample.
  - sclk_rise / sclk_fall / cs_fall / cs_rise are each one-clk strobes.
- Clock ratio: clk ≥ 8× sclk is required. Pin-to-strobe latency is SYNC_STAGES+1 clk.
- Arming: after reset the block ignores all traffic until synchronised cs_n has been seen high for ≥1 clk (armed=1). This prevents joining a frame mid-byte.
- States:
  - IDLE (cs_n_s=1): bit_cnt held 0, miso=0, sclk edges ignored.
  - ACTIVE (cs_n_s=0 and armed).
  - IDLE→ACTIVE on cs_fall: bit_cnt=0, tx_shift<=tx_data, miso<=tx_data[7] in the same clk.
  - ACTIVE→IDLE on cs_rise.
- sclk_rise in ACTIVE:
  - rx_shift<={rx_shift[6:0],mosi_s}; bit_cnt<=bit_cnt+1 (3-bit, wraps 7→0).
  - If bit_cnt was 7: rx_data<={rx_shift[6:0],mosi_s} and byte_sync=1 in the next clk, for exactly one clk.
- sclk_fall in ACTIVE:
  - If bit_cnt==0 (byte boundary): tx_shift<=tx_data sampled this clk, miso<=tx_data[7].
  - Else: tx_shift<=tx_shift<<1, miso<=tx_shift[6].
  - tx_data must be valid ≤2 clk after byte_sync. At 8× ratio, the 8th falling edge lands ≥3 clk after byte_sync.
- Boundary conditions:
  - **cs_n rises mid-byte (bit_cnt≠0):** partial byte discarded, no byte_sync, rx_data unchanged.
  - **sclk_rise and cs_rise in same clk:** the edge is processed, because the condition uses cs_n_s of the previous clk. If it completes a byte, byte_sync still fires.
  - **Back-to-back bytes in one frame:** bit_cnt wraps; no gap required.
  - **rst asserted mid-frame:** immediate return to reset values; re-arm as above.
  - **sclk edges while cs_n high:** ignored; miso=0.

Optional Feature:
SPI_FRAME_ERR_EN
- With the macro: adds output frame_err (1 bit, reset 0).
  - Set on cs_rise when bit_cnt≠0.
  - Sticky; cleared on the next cs_fall or rst.
- Without the macro: port absent; mid-byte abort is silently discarded as above.

Decomposition:
- Package spi_pkg: BYTE_W=8, BIT_CNT_W=3, state enum {SPI_IDLE, SPI_ACTIVE}, MIN_CLK_RATIO=8.
- One sub-module, sync_edge (parameter SYNC_STAGES, reset value input as parameter). It outputs the synchronised level plus rise/fall strobes. Instantiated for sclk and cs_n; mosi uses a plain synchroniser.

Test Plan:
- Reset, then one frame (cs low, MOSI 8'hA5, clk=10× sclk) -> exactly one byte_sync pulse; rx_data=8'hA5; miso=0 while cs high.
- tx_data=8'h3C held at cs_fall, master clocks 8 bits -> MISO bits sampled on sclk rising = 0,0,1,1,1,1,0,0.
- Two-byte frame: MOSI 8'h85 then 8'h7E; bench drives tx_data=8'hC3 within 2 clk of first byte_sync -> two byte_sync pulses, rx_data 8'h85 then 8'h7E; second MISO byte = 8'hC3.
- cs_n released after 5 bits of 8'hFF -> no byte_sync, rx_data keeps prior value. With SPI_FRAME_ERR_EN: frame_err=1 until next cs_fall.
- rst pulsed while cs_n low at bit 3, cs_n kept low, 8 more sclk -> no byte_sync. Next frame after cs_n high then low receives 8'h5A correctly.
- 8th sclk rising and cs_n rising land in the same clk after sync -> byte_sync still pulses with the correct byte.
